// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the burst-length helper used by the arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HB_SINGLE = 3'd0,
        HB_INCR   = 3'd1,
        HB_WRAP4  = 3'd2,
        HB_INCR4  = 3'd3,
        HB_WRAP8  = 3'd4,
        HB_INCR8  = 3'd5,
        HB_WRAP16 = 3'd6,
        HB_INCR16 = 3'd7
    } hburst_e;

    localparam logic [1:0] HRESP_OKAY  = 2'd0;
    localparam logic [1:0] HRESP_ERROR = 2'd1;
    localparam int         BEATS_W     = 5;

    // Beats still owed after the NONSEQ of a fixed-length burst.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HB_WRAP4,  HB_INCR4:  burst_beats = 5'd3;
            HB_WRAP8,  HB_INCR8:  burst_beats = 5'd7;
            HB_WRAP16, HB_INCR16: burst_beats = 5'd15;
            default:              burst_beats = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational next-owner selector: round-robin after last_i, or lowest index.
module ahb_rr_picker #(
    parameter int N  = 2,
    parameter int MW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [MW-1:0] last_i,
    input  logic          mode_i,
    output logic [MW-1:0] idx_o,
    output logic          vld_o
);

    logic [MW-1:0] j;

    always_comb begin
        idx_o = last_i;
        vld_o = 1'b0;
        j     = '0;
        if (mode_i) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    idx_o = MW'(i);
                    vld_o = 1'b1;
                end
            end
        end else begin
            // Descending scan so the nearest requester after last_i wins.
            for (int k = N - 1; k >= 1; k--) begin
                j = MW'((int'(last_i) + k) % N);
                if (req_i[j]) begin
                    idx_o = j;
                    vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// N-master AHB-lite arbiter and bus mux; holds ownership across bursts and locks.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ARB_MODE    = 0,
    parameter int MW          = $clog2(NUM_MASTERS)
) (
    input  logic                             hclk,
    input  logic                             hresetn,
    input  logic [2*NUM_MASTERS-1:0]          m_htrans_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_haddr_i,
    input  logic [NUM_MASTERS-1:0]            m_hwrite_i,
    input  logic [3*NUM_MASTERS-1:0]          m_hsize_i,
    input  logic [3*NUM_MASTERS-1:0]          m_hburst_i,
    input  logic [4*NUM_MASTERS-1:0]          m_hprot_i,
    input  logic [NUM_MASTERS-1:0]            m_hmastlock_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_hwdata_i,
    output logic [NUM_MASTERS-1:0]            m_hready_o,
    output logic [DATA_WIDTH-1:0]             m_hrdata_o,
    output logic [1:0]                        m_hresp_o,
    output logic [1:0]                        htrans_o,
    output logic [ADDR_WIDTH-1:0]             haddr_o,
    output logic                              hwrite_o,
    output logic [2:0]                        hsize_o,
    output logic [2:0]                        hburst_o,
    output logic [3:0]                        hprot_o,
    output logic                              hmastlock_o,
    output logic [DATA_WIDTH-1:0]             hwdata_o,
    input  logic                              hready_i,
    input  logic [DATA_WIDTH-1:0]             hrdata_i,
    input  logic [1:0]                        hresp_i,
    output logic [MW-1:0]                     grant_o,
    output logic                              burst_err_o
);

    logic [NUM_MASTERS-1:0][1:0]            trans_a;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_MASTERS-1:0][2:0]            size_a, burst_a;
    logic [NUM_MASTERS-1:0][3:0]            prot_a;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] wdata_a;

    assign trans_a = m_htrans_i;
    assign addr_a  = m_haddr_i;
    assign size_a  = m_hsize_i;
    assign burst_a = m_hburst_i;
    assign prot_a  = m_hprot_i;
    assign wdata_a = m_hwdata_i;

    logic [MW-1:0]      grant_q, grant_d, downer_q, downer_d, pick_idx;
    logic [BEATS_W-1:0] beats_q, beats_d;
    logic               err_q, err_d, pick_vld, switch_ok;
    logic [1:0]         own_trans;
    logic [NUM_MASTERS-1:0] req_oth;

    assign own_trans = trans_a[grant_q];

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++)
            req_oth[i] = (trans_a[i] == HT_NONSEQ) && (MW'(i) != grant_q);
    end

    ahb_rr_picker #(.N(NUM_MASTERS), .MW(MW)) u_pick (
        .req_i  (req_oth),
        .last_i (grant_q),
        .mode_i (ARB_MODE != 0),
        .idx_o  (pick_idx),
        .vld_o  (pick_vld)
    );

    assign switch_ok = hready_i && (own_trans == HT_IDLE) && !m_hmastlock_i[grant_q]
                    && (beats_q == '0) && pick_vld;

    always_comb begin
        grant_d  = grant_q;
        downer_d = downer_q;
        beats_d  = beats_q;
        err_d    = 1'b0;
        if (hready_i) begin
            downer_d = grant_q;
            if (switch_ok) grant_d = pick_idx;
            case (own_trans)
                HT_NONSEQ: begin
                    err_d   = (beats_q != '0);
                    beats_d = burst_beats(burst_a[grant_q]);
                end
                HT_SEQ:  if (beats_q != '0) beats_d = beats_q - 5'd1;
                HT_IDLE: begin
                    err_d   = (beats_q != '0);
                    beats_d = '0;
                end
                default: ;
            endcase
        end
        // Early termination after ERROR is legal; a fresh NONSEQ still loads.
        if (hresp_i == HRESP_ERROR) begin
            err_d = 1'b0;
            if (!(hready_i && own_trans == HT_NONSEQ)) beats_d = '0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q  <= '0;
            downer_q <= '0;
            beats_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            grant_q  <= grant_d;
            downer_q <= downer_d;
            beats_q  <= beats_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        m_hready_o          = '0;
        m_hready_o[grant_q] = hready_i;
    end

    assign m_hrdata_o  = hrdata_i;
    assign m_hresp_o   = hresp_i;
    assign htrans_o    = own_trans;
    assign haddr_o     = addr_a[grant_q];
    assign hwrite_o    = m_hwrite_i[grant_q];
    assign hsize_o     = size_a[grant_q];
    assign hburst_o    = burst_a[grant_q];
    assign hprot_o     = prot_a[grant_q];
    assign hmastlock_o = m_hmastlock_i[grant_q];
    assign hwdata_o    = wdata_a[downer_q];
    assign grant_o     = grant_q;
    assign burst_err_o = err_q;

endmodule
